joybus_tx: RTL and testbench
============================

Name: joybus_tx

Overview:
- Parametrised Joybus transmitter for the fake N64 controller.
- Serialises a variable-length response payload of 1..MAX_BYTES bytes, MSB first, using 4-level bit encoding, then appends the stop bit.
- Drives the bus open-drain and signals the receiver when the line is released.
- Sits between the command decoder, which supplies the payload and starts transmission, and the Joybus pad.

Parameters:
- LEVEL_WIDTH, 2, sample_clk cycles per level; legal range 1..63.
- MAX_BYTES, 4, maximum payload length in bytes; legal range 1..32.
- CNT_W, $clog2(8*MAX_BYTES+1), width of the bit counter and of byte_count.

Ports:
- sample_clk  in  1  system clock; every event is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; requests transmission of the payload.
- byte_count  in  CNT_W  number of bytes to send; sampled with start.
- payload  in  8*MAX_BYTES  response data; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the stop bit.
- err  out  1  one-cycle pulse when a start is rejected.
- rx_handoff  out  1  one-cycle pulse coincident with done; hands the line to the receiver.
- tx_drive_low  out  1  1 = pull the line low, 0 = release (HIGH via pull-up).

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy, done, err, rx_handoff and tx_drive_low all 0; all counters 0. A reset during transmission aborts immediately and releases the line. No done pulse is issued.
- Encoding: level L = tx_drive_low 1; level H = tx_drive_low 0.
  - Logical 0 = L,L,L,H.
  - Logical 1 = L,H,H,H.
  - Stop bit = L,L,H, i.e. 3 levels.
  - Each level lasts exactly LEVEL_WIDTH cycles.
- Bit order: the first bit sent is payload[8*byte_count-1], descending to payload[0]. Bits above 8*byte_count are ignored.
- States:
  - IDLE: on start, with 1 <= byte_count <= MAX_BYTES, latch payload and byte_count and go to DATA. Otherwise pulse err and stay in IDLE.
  - DATA: the level counter advances each LEVEL_WIDTH cycles. After 4 levels the bit counter increments. When the bit counter reaches 8*byte_count, go to STOP.
  - STOP: emit L,L,H, then go to FINISH.
  - FINISH: for one cycle, done=1, rx_handoff=1, busy=0 and tx_drive_low=0, then return to IDLE.
- Latency: the start-accept edge is cycle 0. tx_drive_low=1 from cycle 1, which is the first L level.
- Frame length: busy is high for N*32*LEVEL_WIDTH + 3*LEVEL_WIDTH cycles, where N = byte_count. The done pulse comes in the cycle after that window.
- start while busy is ignored: no err, and the frame is unaffected.
- payload and byte_count changes during busy have no effect, because the values are latched at accept.
- start in the FINISH cycle is ignored. A start in the following cycle is accepted, so back-to-back frames have a 1-cycle gap with the line released.
- tx_drive_low is registered and glitch-free. No combinational path exists from inputs to tx_drive_low.

Decomposition:
- Package joybus_pkg holds:
  - the state encodings (IDLE, DATA, STOP, FINISH; 2 bits);
  - the level patterns ENC_ZERO=4'b1110 and ENC_ONE=4'b1000 as drive-low vectors, index 3 first;
  - STOP_PATTERN=3'b110.
- Sub-module joybus_level_timer (LEVEL_WIDTH): a cycle counter with a synchronous clear. It outputs a level_tick pulse every LEVEL_WIDTH cycles and a 2-bit level index.
- joybus_tx owns the FSM, the shift register and the bit counter.

Test Plan:
- LEVEL_WIDTH=2, byte_count=3, payload=24'h050000 → frame decodes to 0x05,0x00,0x00 MSB first. Stop bit L,L,H. busy high for exactly 198 cycles. done and rx_handoff pulse once.
- byte_count=4, payload=32'h80000001 → first bit L,H,H,H (4 levels × 2 cycles), bits 2..31 pattern L,L,L,H, last bit L,H,H,H. Busy for 262 cycles.
- byte_count=0, and byte_count=MAX_BYTES+1 → err pulses for 1 cycle. busy and tx_drive_low stay 0.
- start re-pulsed at cycle 50 of a 3-byte frame with a different payload → the waveform is identical to the first test and no err is raised.
- reset_n asserted at cycle 40 → tx_drive_low=0 and busy=0 immediately (asynchronously). After release, a new start yields a correct full frame.
- LEVEL_WIDTH=1, MAX_BYTES=1, byte_count=1, payload=8'hA5 → 35-cycle frame with exact level timing. Back-to-back start in the cycle after FINISH is accepted.

Source files
------------

// File: rtl/joybus_pkg.sv
// Shared encodings for the Joybus transmitter: FSM states and the
// drive-low level patterns for data bits and the stop bit.
package joybus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_STOP   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Drive-low vectors, index 3 is the first level on the wire.
    localparam logic [3:0] ENC_ZERO     = 4'b1110;
    localparam logic [3:0] ENC_ONE      = 4'b1000;
    localparam logic [2:0] STOP_PATTERN = 3'b110;

    function automatic logic data_level(input logic bit_val, input logic [1:0] lvl);
        logic [3:0] pat;
        pat = bit_val ? ENC_ONE : ENC_ZERO;
        return pat[~lvl];
    endfunction

    function automatic logic stop_level(input logic [1:0] lvl);
        logic [3:0] pat;
        pat = {STOP_PATTERN, 1'b0};
        return pat[~lvl];
    endfunction

endpackage

// File: rtl/joybus_level_timer.sv
// Level timer: ticks once every LEVEL_WIDTH cycles and counts the level
// index within a bit; synchronous clear holds it at the start of a level.
module joybus_level_timer #(
    parameter int LEVEL_WIDTH = 2
) (
    input  logic       sample_clk,
    input  logic       reset_n,
    input  logic       i_clear,
    output logic       o_level_tick,
    output logic [1:0] o_level_idx
);

    localparam int CW = (LEVEL_WIDTH > 1) ? $clog2(LEVEL_WIDTH) : 1;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;

    assign o_level_tick = !i_clear && (r_cnt == CW'(LEVEL_WIDTH - 1));
    assign o_level_idx  = r_idx;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (o_level_tick) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/joybus_tx.sv
// Joybus response transmitter: serialises 1..MAX_BYTES bytes MSB first with
// 4-level bit encoding plus a 3-level stop bit, driving the line open-drain.
module joybus_tx
    import joybus_pkg::*;
#(
    parameter int LEVEL_WIDTH = 2,
    parameter int MAX_BYTES   = 4,
    parameter int CNT_W       = $clog2(8 * MAX_BYTES + 1)
) (
    input  logic                   sample_clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       byte_count,
    input  logic [8*MAX_BYTES-1:0] payload,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   rx_handoff,
    output logic                   tx_drive_low
);

    localparam int PW = 8 * MAX_BYTES;

    state_t           r_state, w_state_next;
    logic [PW-1:0]    r_shift, w_shift_next;
    logic [CNT_W-1:0] r_nbytes, r_bit_cnt, w_bit_cnt_next;
    logic [CNT_W-1:0] w_bits_total;
    logic [CNT_W+2:0] w_shamt;
    logic [1:0]       w_lvl, w_lvl_next;
    logic             w_tick, w_clear, w_valid, w_accept, w_drive_next;
    logic             r_busy, r_done, r_err, r_drive;

    joybus_level_timer #(.LEVEL_WIDTH(LEVEL_WIDTH)) u_timer (
        .sample_clk  (sample_clk),
        .reset_n     (reset_n),
        .i_clear     (w_clear),
        .o_level_tick(w_tick),
        .o_level_idx (w_lvl)
    );

    assign w_valid      = (byte_count != '0) && (byte_count <= CNT_W'(MAX_BYTES));
    assign w_accept     = (r_state == ST_IDLE) && start && w_valid;
    assign w_clear      = (r_state == ST_IDLE) || (r_state == ST_FINISH);
    assign w_shamt      = {CNT_W'(MAX_BYTES) - byte_count, 3'b000};
    assign w_bits_total = r_nbytes << 3;
    assign w_lvl_next   = w_clear ? 2'd0 : (w_tick ? w_lvl + 2'd1 : w_lvl);

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // The line is driven from a register, so its value is computed from the
    // next-cycle state, level and bit to land exactly on the level boundary.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal (no latches).
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_drive_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next   = ST_DATA;
                    w_shift_next   = payload << w_shamt;
                    w_bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (w_tick && w_lvl == 2'd3) begin
                    w_shift_next   = r_shift << 1;
                    w_bit_cnt_next = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt + CNT_W'(1) == w_bits_total) w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick && w_lvl == 2'd2) w_state_next = ST_FINISH;
            end
            default: w_state_next = ST_IDLE;
        endcase
        case (w_state_next)
            ST_DATA: w_drive_next = data_level(w_shift_next[PW-1], w_lvl_next);
            ST_STOP: w_drive_next = stop_level(w_lvl_next);
            default: w_drive_next = 1'b0;
        endcase
    end

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_nbytes  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_drive   <= 1'b0;
        end else begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            if (w_accept) r_nbytes <= byte_count;
            r_busy    <= (w_state_next == ST_DATA) || (w_state_next == ST_STOP);
            r_done    <= (w_state_next == ST_FINISH);
            r_err     <= (r_state == ST_IDLE) && start && !w_valid;
            r_drive   <= w_drive_next;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign rx_handoff   = r_done;
    assign err          = r_err;
    assign tx_drive_low = r_drive;

endmodule

// File: tb/tb_joybus_tx.sv
// Self-checking bench for joybus_tx: two instances (LEVEL_WIDTH=2/MAX_BYTES=4
// and LEVEL_WIDTH=1/MAX_BYTES=1) compared cycle by cycle against a waveform model.
module tb_joybus_tx;

    logic        sample_clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  bc;
    logic [31:0] pl;
    logic        sel;

    logic busy_a, done_a, err_a, rx_a, drive_a;
    logic busy_b, done_b, err_b, rx_b, drive_b;
    logic o_busy, o_done, o_err, o_rx, o_drive;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sample_clk = ~sample_clk;

    joybus_tx #(.LEVEL_WIDTH(2), .MAX_BYTES(4)) dut_a (
        .sample_clk  (sample_clk),
        .reset_n     (reset_n),
        .start       (start & ~sel),
        .byte_count  (bc),
        .payload     (pl),
        .busy        (busy_a),
        .done        (done_a),
        .err         (err_a),
        .rx_handoff  (rx_a),
        .tx_drive_low(drive_a)
    );

    joybus_tx #(.LEVEL_WIDTH(1), .MAX_BYTES(1)) dut_b (
        .sample_clk  (sample_clk),
        .reset_n     (reset_n),
        .start       (start & sel),
        .byte_count  (bc[3:0]),
        .payload     (pl[7:0]),
        .busy        (busy_b),
        .done        (done_b),
        .err         (err_b),
        .rx_handoff  (rx_b),
        .tx_drive_low(drive_b)
    );

    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_done  = sel ? done_b  : done_a;
    assign o_err   = sel ? err_b   : err_a;
    assign o_rx    = sel ? rx_b    : rx_a;
    assign o_drive = sel ? drive_b : drive_a;

    // Runs one frame on the selected DUT starting at the current negedge and
    // ends at the negedge of the first idle cycle after the done pulse.
    task automatic run_frame(input int n, input logic [31:0] data,
                             input int restart_at, input bit prestart);
        bit   wave[$];
        int   lw;
        int   len;
        logic v, lv, exp_drive, exp_busy, exp_done;
        lw = sel ? 1 : 2;
        for (int b = 8 * n - 1; b >= 0; b--) begin
            v = data[b];
            for (int l = 0; l < 4; l++) begin
                lv = (l == 0) ? 1'b1 : (v ? 1'b0 : (l < 3));
                repeat (lw) wave.push_back(lv);
            end
        end
        repeat (lw) wave.push_back(1'b1);
        repeat (lw) wave.push_back(1'b1);
        repeat (lw) wave.push_back(1'b0);
        len = wave.size();

        n_checks++;
        if (o_busy !== 1'b0 || o_drive !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_before_start busy=%0b drive=%0b done=%0b required=0/0/0",
                     o_busy, o_drive, o_done);
        end
        start = 1'b1; bc = 6'(n); pl = data;
        @(negedge sample_clk);
        start = 1'b0; bc = 6'($urandom); pl = $urandom;
        for (int k = 1; k <= len + 1; k++) begin
            exp_drive = (k <= len) ? wave[k-1] : 1'b0;
            exp_busy  = (k <= len);
            exp_done  = (k == len + 1);
            n_checks++;
            if (o_drive !== exp_drive) begin
                n_fail++;
                $display("FAIL drive cycle=%0d got=%0b required=%0b", k, o_drive, exp_drive);
            end
            n_checks++;
            if (o_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy cycle=%0d got=%0b required=%0b", k, o_busy, exp_busy);
            end
            n_checks++;
            if (o_done !== exp_done || o_rx !== exp_done) begin
                n_fail++;
                $display("FAIL done_handoff cycle=%0d done=%0b rx=%0b required=%0b",
                         k, o_done, o_rx, exp_done);
            end
            n_checks++;
            if (o_err !== 1'b0) begin
                n_fail++;
                $display("FAIL err_in_frame cycle=%0d got=%0b required=0", k, o_err);
            end
            if (k == restart_at) begin
                start = 1'b1; bc = 6'((n == 1) ? 2 : 1); pl = ~data;
            end else if (k == restart_at + 1) begin
                start = 1'b0;
            end
            if (k == len + 1 && prestart) begin
                start = 1'b1; bc = 6'(sel ? 1 : 4); pl = $urandom;
            end
            @(negedge sample_clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; bc = '0; pl = '0; sel = 1'b0;
        repeat (3) @(negedge sample_clk);
        n_checks++;
        if ({busy_a, done_a, err_a, rx_a, drive_a} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_a got=%b required=00000", {busy_a, done_a, err_a, rx_a, drive_a});
        end
        n_checks++;
        if ({busy_b, done_b, err_b, rx_b, drive_b} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_b got=%b required=00000", {busy_b, done_b, err_b, rx_b, drive_b});
        end
        reset_n = 1'b1;
        @(negedge sample_clk);
    endtask

    task automatic test_err();
        int bad [4];
        bit sl  [4];
        bad = '{0, 5, 0, 2};
        sl  = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            sel = sl[i];
            start = 1'b1; bc = 6'(bad[i]); pl = $urandom;
            @(negedge sample_clk);
            start = 1'b0;
            n_checks++;
            if (o_err !== 1'b1 || o_busy !== 1'b0 || o_drive !== 1'b0) begin
                n_fail++;
                $display("FAIL err_pulse bc=%0d err=%0b busy=%0b drive=%0b required=1/0/0",
                         bad[i], o_err, o_busy, o_drive);
            end
            @(negedge sample_clk);
            n_checks++;
            if (o_err !== 1'b0 || o_busy !== 1'b0 || o_drive !== 1'b0) begin
                n_fail++;
                $display("FAIL err_single bc=%0d err=%0b busy=%0b drive=%0b required=0/0/0",
                         bad[i], o_err, o_busy, o_drive);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        sel = 1'b0;
        start = 1'b1; bc = 6'd3; pl = $urandom;
        @(negedge sample_clk);
        start = 1'b0;
        repeat (39) @(negedge sample_clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (drive_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset drive=%0b busy=%0b required=0/0", drive_a, busy_a);
        end
        @(negedge sample_clk);
        n_checks++;
        if (done_a !== 1'b0 || rx_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done done=%0b rx=%0b required=0/0", done_a, rx_a);
        end
        reset_n = 1'b1;
        @(negedge sample_clk);
        run_frame(3, $urandom, -1, 1'b0);
    endtask

    task automatic test_random_a();
        sel = 1'b0;
        for (int i = 0; i < 5; i++) run_frame($urandom_range(1, 4), $urandom, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        run_frame(1, 32'h0000_00A5, -1, 1'b1);
        run_frame(1, $urandom, -1, 1'b1);
        run_frame(1, $urandom, -1, 1'b0);
        sel = 1'b0;
        run_frame(2, $urandom, -1, 1'b1);
        run_frame(1, $urandom, -1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        sel = 1'b0;
        run_frame(3, 32'h0005_0000, -1, 1'b0);
        run_frame(4, 32'h8000_0001, -1, 1'b0);
        test_err();
        run_frame(3, 32'h0005_0000, 50, 1'b0);
        test_reset_mid_frame();
        test_random_a();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
